// File: rtl/pipe_alu_fwd.sv
// pipe_alu_fwd: four-stage register-bank ALU pipeline with full operand
// forwarding, a global stall, an illegal-opcode flag, an optional store to a
// local data memory and a registered memory read port.
//
// Stages for an instruction accepted at edge E:
//   E   : operands (forwarded) and fields captured into S1
//   E+1 : ALU result captured into S2
//   E+2 : regbank[rd] written (legal func only); zout / zout_valid / err_func
//   E+3 : mem[addr] written when st_en and func is legal
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready instruction handshake
//   stall             freezes every pipeline register and all writes
//   rs1, rs2, rd      source / destination register addresses
//   func              opcode (14, 15 illegal)
//   addr, st_en       store address and enable
//   zout, zout_valid  retired result and its one-cycle valid strobe
//   err_func          retired instruction had an illegal func
//   mem_raddr         read address for the memory read port
//   mem_rdata         registered read data, one-cycle latency, write-first
//
// Handshake: an instruction is taken on a rising edge where
// in_valid && in_ready; in_ready is simply ~stall, so the source must hold its
// fields stable for as long as stall is high.
module pipe_alu_fwd #(
  parameter int DATA_W       = 16,
  parameter int RA_W         = 4,
  parameter int MA_W         = 8,
  parameter int REG_INIT_IDX = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              stall,
  input  logic [RA_W-1:0]   rs1,
  input  logic [RA_W-1:0]   rs2,
  input  logic [RA_W-1:0]   rd,
  input  logic [3:0]        func,
  input  logic [MA_W-1:0]   addr,
  input  logic              st_en,
  output logic [DATA_W-1:0] zout,
  output logic              zout_valid,
  output logic              err_func,
  input  logic [MA_W-1:0]   mem_raddr,
  output logic [DATA_W-1:0] mem_rdata
);

  localparam int NREG = 2 ** RA_W;
  localparam int NMEM = 2 ** MA_W;

  logic [DATA_W-1:0] regbank [NREG];
  logic [DATA_W-1:0] mem     [NMEM];

  // S1: captured operands and fields
  logic              s1_valid;
  logic [RA_W-1:0]   s1_rd;
  logic [3:0]        s1_func;
  logic [DATA_W-1:0] s1_a;
  logic [DATA_W-1:0] s1_b;
  logic [MA_W-1:0]   s1_addr;
  logic              s1_st;

  // S2: ALU result
  logic              s2_valid;
  logic [RA_W-1:0]   s2_rd;
  logic [DATA_W-1:0] s2_res;
  logic              s2_legal;
  logic [MA_W-1:0]   s2_addr;
  logic              s2_st;

  // S3: pending store (valid, legal and st_en already folded together)
  logic              s3_store;
  logic [MA_W-1:0]   s3_addr;
  logic [DATA_W-1:0] s3_res;

  logic [DATA_W-1:0] alu_res;
  logic              s1_legal;
  logic [DATA_W-1:0] op_a;
  logic [DATA_W-1:0] op_b;
  logic              mem_we;

  assign in_ready = ~stall;
  assign s1_legal = (s1_func < 4'd14);
  assign mem_we   = s3_store & ~stall;

  always_comb begin
    alu_res = '0;
    case (s1_func)
      4'd0:    alu_res = s1_a + s1_b;
      4'd1:    alu_res = s1_a - s1_b;
      4'd2:    alu_res = s1_a * s1_b;
      4'd3:    alu_res = s1_a;
      4'd4:    alu_res = s1_b;
      4'd5:    alu_res = s1_a & s1_b;
      4'd6:    alu_res = s1_a | s1_b;
      4'd7:    alu_res = s1_a ^ s1_b;
      4'd8:    alu_res = -s1_a;
      4'd9:    alu_res = -s1_b;
      4'd10:   alu_res = s1_a >> 1;
      4'd11:   alu_res = s1_a << 1;
      4'd12:   alu_res = $unsigned($signed(s1_a) >>> 1);
      4'd13:   alu_res = {{(DATA_W-1){1'b0}}, (s1_a < s1_b)};
      default: alu_res = '0;
    endcase
  end

  // Operand forwarding: later assignments win, so the youngest producer
  // (S1, still in the ALU) overrides S2, which overrides the regbank. S2 is
  // writing the regbank on the same edge, so its forward is what keeps a
  // same-edge read from seeing the stale value.
  always_comb begin
    op_a = regbank[rs1];
    op_b = regbank[rs2];
    if (s2_valid && s2_legal && (s2_rd == rs1)) op_a = s2_res;
    if (s2_valid && s2_legal && (s2_rd == rs2)) op_b = s2_res;
    if (s1_valid && s1_legal && (s1_rd == rs1)) op_a = alu_res;
    if (s1_valid && s1_legal && (s1_rd == rs2)) op_b = alu_res;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_rd      <= '0;
      s1_func    <= '0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_addr    <= '0;
      s1_st      <= 1'b0;
      s2_valid   <= 1'b0;
      s2_rd      <= '0;
      s2_res     <= '0;
      s2_legal   <= 1'b0;
      s2_addr    <= '0;
      s2_st      <= 1'b0;
      s3_store   <= 1'b0;
      s3_addr    <= '0;
      s3_res     <= '0;
      zout       <= '0;
      zout_valid <= 1'b0;
      err_func   <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        regbank[i] <= (REG_INIT_IDX != 0) ? DATA_W'(i) : '0;
      end
    end else if (stall) begin
      // Everything holds; only the retire strobes drop.
      zout_valid <= 1'b0;
      err_func   <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_rd    <= rd;
      s1_func  <= func;
      s1_a     <= op_a;
      s1_b     <= op_b;
      s1_addr  <= addr;
      s1_st    <= st_en;

      s2_valid <= s1_valid;
      s2_rd    <= s1_rd;
      s2_res   <= alu_res;
      s2_legal <= s1_legal;
      s2_addr  <= s1_addr;
      s2_st    <= s1_st;

      if (s2_valid && s2_legal) regbank[s2_rd] <= s2_res;
      zout_valid <= s2_valid;
      err_func   <= s2_valid & ~s2_legal;
      if (s2_valid) zout <= s2_res;

      s3_store <= s2_valid & s2_legal & s2_st;
      s3_addr  <= s2_addr;
      s3_res   <= s2_res;
    end
  end

  // Data memory has no reset; writes are gated by s3_store, which reset clears.
  always_ff @(posedge clk) begin
    if (mem_we) mem[s3_addr] <= s3_res;
  end

  // Read port runs through stall; a store to the same address on the same
  // edge is returned directly (write-first).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rdata <= '0;
    end else if (mem_we && (s3_addr == mem_raddr)) begin
      mem_rdata <= s3_res;
    end else begin
      mem_rdata <= mem[mem_raddr];
    end
  end

endmodule

// File: tb/tb_pipe_alu_fwd.sv
// Bench for pipe_alu_fwd: a 16-bit instance carries most of the directed
// sequence, an 8-bit instance covers wrap-around with forwarding. Results are
// predicted by a sequential reference model at issue time and matched against
// retirements in order.
module tb_pipe_alu_fwd;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_valid8;
  logic        stall;
  logic [3:0]  rs1, rs2, rd, func;
  logic [7:0]  addr;
  logic        st_en;
  logic [7:0]  mem_raddr;

  logic        in_ready;
  logic [15:0] zout;
  logic        zout_valid;
  logic        err_func;
  logic [15:0] mem_rdata;

  logic        rdy8;
  logic [7:0]  z8;
  logic        zv8;
  logic        err8;
  logic [7:0]  rdata8;

  int checks;
  int errors;

  logic [16:0] exp_q[$];
  logic [8:0]  exp8_q[$];

  logic [31:0] m_reg  [16];
  logic [31:0] m8_reg [16];
  logic [31:0] m_mem  [256];

  pipe_alu_fwd #(.DATA_W(16), .RA_W(4), .MA_W(8), .REG_INIT_IDX(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .stall(stall), .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .st_en(st_en), .zout(zout), .zout_valid(zout_valid), .err_func(err_func),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  pipe_alu_fwd #(.DATA_W(8), .RA_W(4), .MA_W(8), .REG_INIT_IDX(1)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(rdy8),
    .stall(stall), .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .st_en(st_en), .zout(z8), .zout_valid(zv8), .err_func(err8),
    .mem_raddr(mem_raddr), .mem_rdata(rdata8)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_alu(input int w, input logic [3:0] f,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [31:0] m;
    logic [31:0] r;
    m = (32'd1 << w) - 32'd1;
    case (f)
      4'd0:    r = a + b;
      4'd1:    r = a - b;
      4'd2:    r = a * b;
      4'd3:    r = a;
      4'd4:    r = b;
      4'd5:    r = a & b;
      4'd6:    r = a | b;
      4'd7:    r = a ^ b;
      4'd8:    r = 32'd0 - a;
      4'd9:    r = 32'd0 - b;
      4'd10:   r = a >> 1;
      4'd11:   r = a << 1;
      4'd12:   r = (a >> 1) | (a & (32'd1 << (w - 1)));
      4'd13:   r = (a < b) ? 32'd1 : 32'd0;
      default: r = 32'd0;
    endcase
    return r & m;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_reg[i]  = i;
      m8_reg[i] = i;
    end
  endtask

  // Scoreboards: one entry per retirement, {err_func, zout}.
  always @(negedge clk) begin
    if (rst_n && zout_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_retire16 observed=%0h expected=none", zout);
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        check("retire16", {15'd0, err_func, zout}, {15'd0, e});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && zv8) begin
      if (exp8_q.size() == 0) begin
        checks++;
        errors++;
        $error("FAIL unexpected_retire8 observed=%0h expected=none", z8);
      end else begin
        logic [8:0] e;
        e = exp8_q.pop_front();
        check("retire8", {23'd0, err8, z8}, {23'd0, e});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Place fields on the inputs and, if tracked, advance the reference model.
  task automatic present(input bit to8, input logic [3:0] f, input logic [3:0] a1,
                         input logic [3:0] a2, input logic [3:0] d,
                         input logic [7:0] ad, input bit st, input bit track);
    logic [31:0] r;
    func = f; rs1 = a1; rs2 = a2; rd = d; addr = ad; st_en = st;
    if (to8) in_valid8 = 1'b1;
    else     in_valid  = 1'b1;
    if (track) begin
      if (to8) begin
        r = ref_alu(8, f, m8_reg[a1], m8_reg[a2]);
        exp8_q.push_back({(f >= 4'd14), r[7:0]});
        if (f < 4'd14) m8_reg[d] = r;
      end else begin
        r = ref_alu(16, f, m_reg[a1], m_reg[a2]);
        exp_q.push_back({(f >= 4'd14), r[15:0]});
        if (f < 4'd14) m_reg[d] = r;
        if (f < 4'd14 && st) m_mem[ad] = r;
      end
    end
  endtask

  task automatic issue(input bit to8, input logic [3:0] f, input logic [3:0] a1,
                       input logic [3:0] a2, input logic [3:0] d,
                       input logic [7:0] ad, input bit st, input bit track);
    present(to8, f, a1, a2, d, ad, st, track);
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_valid8 = 1'b0;
  endtask

  task automatic drain();
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic mem_check(input string tag, input logic [7:0] a, input logic [31:0] exp);
    mem_raddr = a;
    @(posedge clk);
    #1;
    check(tag, {16'd0, mem_rdata}, exp);
  endtask

  // ---------------- directed sequence ----------------
  logic [15:0] z_hold;

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; in_valid = 1'b0; in_valid8 = 1'b0; stall = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; func = '0; addr = '0; st_en = 1'b0;
    mem_raddr = '0;
    model_reset();
    #1;
    check("rst_zout",       {16'd0, zout}, 32'd0);
    check("rst_zout_valid", {31'd0, zout_valid}, 32'd0);
    check("rst_err_func",   {31'd0, err_func}, 32'd0);
    check("rst_mem_rdata",  {16'd0, mem_rdata}, 32'd0);
    check("rst_in_ready",   {31'd0, in_ready}, 32'd1);
    check("rst_rdata8",     {24'd0, rdata8}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Dependent chain, each op consuming the previous result with no bubble.
    issue(0, 4'd0, 4'd2, 4'd3,  4'd4,  8'd109, 1, 1); // r4 = r2+r3
    issue(0, 4'd8, 4'd4, 4'd0,  4'd2,  8'd100, 1, 1); // r2 = -r4
    issue(0, 4'd3, 4'd2, 4'd0,  4'd7,  8'd101, 1, 1); // r7 = r2
    issue(0, 4'd2, 4'd9, 4'd10, 4'd11, 8'd102, 1, 1); // r11 = r9*r10
    drain();
    mem_check("mem109", 8'd109, 32'd5);
    mem_check("mem100", 8'd100, 32'h0000FFFB);
    mem_check("mem101", 8'd101, 32'h0000FFFB);
    mem_check("mem102", 8'd102, 32'd90);

    // 8-bit wrap with forwarding, then read r2 back through the pipe.
    issue(1, 4'd2, 4'd15, 4'd15, 4'd1, 8'd0, 0, 1); // r1 = 225
    issue(1, 4'd0, 4'd1,  4'd1,  4'd2, 8'd0, 0, 1); // r2 = 194
    issue(1, 4'd3, 4'd2,  4'd0,  4'd3, 8'd0, 0, 1); // pass r2
    drain();

    // Random burst over every func, stores into the upper address range.
    for (int i = 0; i < 24; i++) begin
      issue(0, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            8'($urandom_range(200, 255)), 1'($urandom_range(0, 1)), 1);
    end
    drain();
    for (int a = 200; a < 204; a++) begin
      if (m_mem[a] !== 32'bx) mem_check("mem_rand", 8'(a), m_mem[a]);
    end

    // Stall for 3 cycles after the 2nd of 4 accepted ops.
    issue(0, 4'd0, 4'd4,  4'd11, 4'd12, 8'd0, 0, 1);
    issue(0, 4'd1, 4'd12, 4'd4,  4'd13, 8'd0, 0, 1);
    z_hold = zout;
    stall  = 1'b1;
    present(0, 4'd7, 4'd13, 4'd12, 4'd14, 8'd0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("stall_in_ready",   {31'd0, in_ready}, 32'd0);
      check("stall_zout_valid", {31'd0, zout_valid}, 32'd0);
      check("stall_zout_hold",  {16'd0, zout}, {16'd0, z_hold});
    end
    stall = 1'b0;
    @(posedge clk);
    #1;
    check("stall_release_retire", {31'd0, zout_valid}, 32'd1);
    issue(0, 4'd12, 4'd14, 4'd0, 4'd15, 8'd0, 0, 1);
    drain();

    // Reset with three ops in flight whose stores must never land.
    issue(0, 4'd3, 4'd1, 4'd0, 4'd1, 8'd60, 1, 1);
    issue(0, 4'd3, 4'd2, 4'd0, 4'd2, 8'd61, 1, 1);
    issue(0, 4'd3, 4'd3, 4'd0, 4'd3, 8'd62, 1, 1);
    drain();
    issue(0, 4'd9,  4'd0, 4'd1, 4'd12, 8'd60, 1, 0);
    issue(0, 4'd11, 4'd2, 4'd0, 4'd13, 8'd61, 1, 0);
    issue(0, 4'd6,  4'd3, 4'd9, 4'd14, 8'd62, 1, 0);
    rst_n = 1'b0;
    #1;
    check("midrst_zout",       {16'd0, zout}, 32'd0);
    check("midrst_zout_valid", {31'd0, zout_valid}, 32'd0);
    check("midrst_mem_rdata",  {16'd0, mem_rdata}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    exp_q.delete();
    exp8_q.delete();
    mem_check("midrst_mem60", 8'd60, m_mem[60]);
    mem_check("midrst_mem61", 8'd61, m_mem[61]);
    mem_check("midrst_mem62", 8'd62, m_mem[62]);
    issue(0, 4'd3, 4'd12, 4'd0, 4'd12, 8'd0, 0, 1); // expects 12
    issue(0, 4'd3, 4'd14, 4'd0, 4'd14, 8'd0, 0, 1); // expects 14
    drain();

    // Illegal func: no write, no store, flag raised, r5 still 5 afterwards.
    issue(0, 4'd3,  4'd3, 4'd0, 4'd9, 8'd50, 1, 1);  // mem[50] = 3
    issue(0, 4'd14, 4'd1, 4'd2, 4'd5, 8'd50, 1, 1);
    issue(0, 4'd0,  4'd5, 4'd0, 4'd6, 8'd0,  0, 1);  // r6 = r5 + r0 = 5
    drain();
    mem_check("illegal_mem50", 8'd50, 32'd3);

    // st_en=0 leaves memory untouched.
    issue(0, 4'd3, 4'd4, 4'd0, 4'd4,  8'd20, 1, 1);  // mem[20] = 4
    issue(0, 4'd3, 4'd7, 4'd0, 4'd11, 8'd20, 0, 1);
    drain();
    mem_check("nostore_mem20", 8'd20, 32'd4);

    // Write-first read: build 0x1234 and store it to the address being read.
    mem_raddr = 8'd30;
    issue(0, 4'd2, 4'd15, 4'd15, 4'd1, 8'd0, 0, 1);  // 225
    issue(0, 4'd0, 4'd1,  4'd8,  4'd1, 8'd0, 0, 1);  // 233
    issue(0, 4'd0, 4'd10, 4'd10, 4'd2, 8'd0, 0, 1);  // 20
    issue(0, 4'd2, 4'd1,  4'd2,  4'd3, 8'd30, 1, 1); // 4660
    repeat (3) @(posedge clk);
    #1;
    check("write_first_rdata", {16'd0, mem_rdata}, 32'h00001234);
    drain();

    check("sb16_empty", exp_q.size(), 32'd0);
    check("sb8_empty",  exp8_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
